// File: rtl/reg_block.sv
// reg_block -- 8 x 16-bit general-purpose register file.
//
// Two combinational read ports and one synchronous write port. Register 0 is
// hardwired to zero. Sits between decode (Rs1/Rs2/Rw) and the ALU/writeback
// path (Rd1/Rd2, WData/WE).
//
// Ports:
//   Clock        system clock, all state changes on the rising edge
//   Reset        synchronous, active-high; clears every register, beats WE
//   WE           write enable
//   Rw           write address
//   WData        write data
//   Rs1, Rs2     read addresses
//   Rd1, Rd2     read data (combinational, zero latency)
//
// Optional build macro: REGBLOCK_WRITE_BYPASS_EN
//   When defined, a read whose address matches an active write (WE=1,
//   Reset=0, Rw!=0) returns WData in the same cycle. Undefined: reads see
//   only stored contents; the new value appears after the rising edge.

module reg_block #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] WData,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2
);

    localparam int NREG = 2 ** ADDR_W;

    // Flops exist only for registers 1..NREG-1. regs is the architectural
    // view: entry 0 is a constant, so it reads zero even before the first
    // reset and no write or X on WE/Rw can ever reach it.
    logic [DATA_W-1:0] store [1:NREG-1];
    logic [DATA_W-1:0] regs  [0:NREG-1];

    always_comb begin
        regs[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            regs[i] = store[i];
        end
    end

    // Per-register decode: an X on WE or Rw makes every compare false, so
    // nothing is written rather than something being corrupted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 1; i < NREG; i++) begin
                store[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (WE && (Rw == ADDR_W'(i))) begin
                    store[i] <= WData;
                end
            end
        end
    end

`ifdef REGBLOCK_WRITE_BYPASS_EN
    logic wr_live;
    assign wr_live = WE && !Reset && (Rw != '0);

    always_comb begin
        Rd1 = regs[Rs1];
        Rd2 = regs[Rs2];
        if (wr_live && (Rs1 == Rw)) Rd1 = WData;
        if (wr_live && (Rs2 == Rw)) Rd2 = WData;
        // Address zero always wins over forwarding.
        if (Rs1 == '0) Rd1 = '0;
        if (Rs2 == '0) Rd2 = '0;
    end
`else
    always_comb begin
        Rd1 = regs[Rs1];
        Rd2 = regs[Rs2];
        if (Rs1 == '0) Rd1 = '0;
        if (Rs2 == '0) Rd2 = '0;
    end
`endif

endmodule

// File: tb/tb_reg_block.sv
// tb_reg_block -- self-checking bench for reg_block.
//
// A shadow model of the register file produces the expected read data; each
// read pushes {Rd1,Rd2} expectations onto a scoreboard queue, which the
// scenario task pops and compares once the outputs have settled.

module tb_reg_block;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              WE;
    logic [ADDR_W-1:0] Rw;
    logic [DATA_W-1:0] WData;
    logic [ADDR_W-1:0] Rs1;
    logic [ADDR_W-1:0] Rs2;
    logic [DATA_W-1:0] Rd1;
    logic [DATA_W-1:0] Rd2;

    reg_block #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock(Clock), .Reset(Reset), .WE(WE), .Rw(Rw), .WData(WData),
        .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2)
    );

    always #5 Clock = ~Clock;

    logic [DATA_W-1:0] model [NREG];
    logic [31:0]       sb [$];
    int                n_vec = 0;
    int                n_err = 0;

    // Present read addresses and queue the model's expectation.
    task automatic drive_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        logic [DATA_W-1:0] e1, e2;
        Rs1 = a1;
        Rs2 = a2;
        e1 = (a1 == 0) ? 16'h0000 : model[a1];
        e2 = (a2 == 0) ? 16'h0000 : model[a2];
        sb.push_back({e1, e2});
    endtask

    // One write strobe spanning a single rising edge; model updated after it.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge Clock);
        WE = 1'b1; Rw = a; WData = d;
        @(negedge Clock);
        WE = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        n_vec++;
        if (dut.regs[0] !== 16'h0000) begin
            n_err++;
            $display("FAIL prereset_reg0 got %h want 0000", dut.regs[0]);
        end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        for (int i = 0; i < NREG; i++) begin
            drive_read(ADDR_W'(i), ADDR_W'(NREG - 1 - i));
            #1;
            exp = sb.pop_front();
            n_vec++;
            if (Rd1 !== exp[31:16] || Rd2 !== exp[15:0]) begin
                n_err++;
                $display("FAIL reset_read addr %0d got %h/%h want %h/%h", i, Rd1, Rd2, exp[31:16], exp[15:0]);
            end
        end
    endtask

    task automatic test_basic_write;
        logic [31:0] exp;
        do_write(3'd5, 16'hA5C3);
        drive_read(3'd5, 3'd5);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if (Rd1 !== 16'hA5C3 || Rd2 !== 16'hA5C3 || {Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL basic_write got %h/%h want a5c3/a5c3", Rd1, Rd2);
        end
        for (int i = 0; i < NREG; i++) begin
            n_vec++;
            if (dut.regs[i] !== model[i]) begin
                n_err++;
                $display("FAIL basic_regs[%0d] got %h want %h", i, dut.regs[i], model[i]);
            end
        end
    endtask

    task automatic test_reg0;
        logic [31:0] exp;
        do_write(3'd2, 16'h2222);
        do_write(3'd0, 16'hFFFF);
        drive_read(3'd0, 3'd2);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if (Rd1 !== 16'h0000 || {Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL reg0_read got %h/%h want %h/%h", Rd1, Rd2, exp[31:16], exp[15:0]);
        end
        for (int i = 0; i < NREG; i++) begin
            n_vec++;
            if (dut.regs[i] !== model[i]) begin
                n_err++;
                $display("FAIL reg0_regs[%0d] got %h want %h", i, dut.regs[i], model[i]);
            end
        end
    endtask

    task automatic test_dual_port;
        logic [31:0] exp;
        do_write(3'd1, 16'h1234);
        do_write(3'd7, 16'hBEEF);
        drive_read(3'd1, 3'd7);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if (Rd1 !== 16'h1234 || Rd2 !== 16'hBEEF || {Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL dual_port got %h/%h want 1234/beef", Rd1, Rd2);
        end
        drive_read(3'd7, 3'd1);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if (Rd1 !== 16'hBEEF || Rd2 !== 16'h1234 || {Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL dual_port_swap got %h/%h want beef/1234", Rd1, Rd2);
        end
    endtask

    task automatic test_reset_priority;
        logic [31:0] exp;
        do_write(3'd3, 16'h1111);
        @(negedge Clock);
        Reset = 1'b1; WE = 1'b1; Rw = 3'd3; WData = 16'h5555;
        @(negedge Clock);
        Reset = 1'b0; WE = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        n_vec++;
        if (dut.regs[3] !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_prio_reg3 got %h want 0000", dut.regs[3]);
        end
        drive_read(3'd3, 3'd7);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if ({Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL reset_prio_read got %h/%h want %h/%h", Rd1, Rd2, exp[31:16], exp[15:0]);
        end
    endtask

    // Read-during-write on the same address: forwarded with the bypass build,
    // old value otherwise; either way the new value is visible after the edge.
    task automatic test_read_during_write;
        logic [31:0] exp;
        logic [DATA_W-1:0] pre;
        do_write(3'd4, 16'h1111);
        @(negedge Clock);
        WE = 1'b1; Rw = 3'd4; WData = 16'h0F0F;
        drive_read(3'd4, 3'd0);
        exp = sb.pop_front();
`ifdef REGBLOCK_WRITE_BYPASS_EN
        pre = 16'h0F0F;
`else
        pre = exp[31:16];
`endif
        #1;
        n_vec++;
        if (Rd1 !== pre || Rd2 !== 16'h0000) begin
            n_err++;
            $display("FAIL rdw_before_edge got %h/%h want %h/0000", Rd1, Rd2, pre);
        end
        @(posedge Clock);
        #1;
        n_vec++;
        if (Rd1 !== 16'h0F0F) begin
            n_err++;
            $display("FAIL rdw_after_edge got %h want 0f0f", Rd1);
        end
        @(negedge Clock);
        WE = 1'b0;
        model[4] = 16'h0F0F;
        // A write aimed at register 0 must not leak through to a zero read.
        WE = 1'b1; Rw = 3'd0; WData = 16'hFFFF;
        drive_read(3'd0, 3'd0);
        #1;
        exp = sb.pop_front();
        n_vec++;
        if ({Rd1, Rd2} !== exp) begin
            n_err++;
            $display("FAIL rdw_reg0 got %h/%h want 0000/0000", Rd1, Rd2);
        end
        @(negedge Clock);
        WE = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] exp;
        for (int it = 0; it < 1000; it++) begin
            if ($urandom_range(0, 3) != 0)
                do_write(ADDR_W'($urandom_range(0, NREG - 1)), DATA_W'($urandom));
            else
                @(negedge Clock);
            drive_read(ADDR_W'($urandom_range(0, NREG - 1)), ADDR_W'($urandom_range(0, NREG - 1)));
            #1;
            exp = sb.pop_front();
            n_vec++;
            if (Rd1 !== exp[31:16] || Rd2 !== exp[15:0]) begin
                n_err++;
                $display("FAIL random it %0d rs %0d/%0d got %h/%h want %h/%h",
                         it, Rs1, Rs2, Rd1, Rd2, exp[31:16], exp[15:0]);
            end
        end
    endtask

    initial begin
        Reset = 1'b0; WE = 1'b0; Rw = '0; WData = '0; Rs1 = '0; Rs2 = '0;
        test_reset();
        test_basic_write();
        test_reg0();
        test_dual_port();
        test_reset_priority();
        test_read_during_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
